cardinal_nic: RTL and testbench

Network interface controller between a processing element and the router's PE port, i.e. the other end of the router's PE input and PE output links. Outbound, it holds one processor-written packet and drives it onto the router's PE input link with the si/ri/di handshake, gated by VC polarity. Inbound, it accepts one packet from the router's PE output link and presents it to the processor through a small memory-mapped register file. Each direction has a one-entry channel buffer with a full flag and a wrapping 16-bit packet counter.

---
 rtl/cardinal_nic.sv | 92 +++++++++
 tb/tb_cardinal_nic.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// cardinal_nic: PE-side network interface with one-entry send and receive
// channel buffers, transfer counters and a small memory-mapped register file.
module cardinal_nic #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            addr,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   input  logic                  nicEn,
   input  logic                  nicWrEn,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [DATA_WIDTH-1:0] net_do,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [DATA_WIDTH-1:0] net_di,
   input  logic                  net_polarity
);

   logic [DATA_WIDTH-1:0] out_buf;
   logic [DATA_WIDTH-1:0] in_buf;
   logic                  out_full;
   logic                  in_full;
   logic [CNT_WIDTH-1:0]  tx_cnt;
   logic [CNT_WIDTH-1:0]  rx_cnt;
   logic [DATA_WIDTH-1:0] in_stat;
   logic [DATA_WIDTH-1:0] out_stat;
   logic                  tx;
   logic                  rx;
   logic                  rd;
   logic                  wr_out;

   assign net_do = out_buf;
   assign net_so = out_full & (out_buf[DATA_WIDTH-1] == net_polarity);
   assign net_ri = ~in_full;

   assign tx     = net_so & net_ro;
   assign rx     = net_si & net_ri;
   assign rd     = nicEn & ~nicWrEn;
   assign wr_out = nicEn & nicWrEn & (addr == 2'b10) & ~out_full;

   // Status word: counter in bits [31:16], full flag in bit 0.
   always_comb begin
      in_stat                    = '0;
      in_stat[16 +: CNT_WIDTH]   = rx_cnt;
      in_stat[0]                 = in_full;
      out_stat                   = '0;
      out_stat[16 +: CNT_WIDTH]  = tx_cnt;
      out_stat[0]                = out_full;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_buf  <= '0;
         in_buf   <= '0;
         out_full <= 1'b0;
         in_full  <= 1'b0;
         tx_cnt   <= '0;
         rx_cnt   <= '0;
         d_out    <= '0;
      end else begin
         if (wr_out) begin
            out_buf  <= d_in;
            out_full <= 1'b1;
         end
         if (tx) begin
            out_full <= 1'b0;
            tx_cnt   <= tx_cnt + 1'b1;
         end
         if (rd && addr == 2'b00)
            in_full <= 1'b0;
         // Arrival is placed last so a set beats a concurrent clear.
         if (rx) begin
            in_buf  <= net_di;
            in_full <= 1'b1;
            rx_cnt  <= rx_cnt + 1'b1;
         end
         if (rd) begin
            unique case (addr)
               2'b00: d_out <= in_buf;
               2'b01: d_out <= in_stat;
               2'b10: d_out <= out_buf;
               2'b11: d_out <= out_stat;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cardinal_nic.sv
// Bench for cardinal_nic: rule-level model checked every cycle plus
// directed register reads with literal expectations.
module tb_cardinal_nic;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  addr = 2'b00;
   logic [63:0] d_in = '0;
   logic [63:0] d_out;
   logic        en = 1'b0;
   logic        we = 1'b0;
   logic        so;
   logic        ro = 1'b0;
   logic [63:0] dout_net;
   logic        si = 1'b0;
   logic        ri;
   logic [63:0] di = '0;
   logic        pol = 1'b0;
   logic        pol_tog = 1'b1;

   logic [1:0]  s_addr = 2'b00;
   logic [63:0] s_din = '0;
   logic [63:0] s_dout;
   logic        s_en = 1'b0;
   logic        s_we = 1'b0;
   logic        s_so;
   logic        s_ri;
   logic [63:0] s_do;

   int checks = 0;
   int errors = 0;
   bit run_chk = 1'b0;

   cardinal_nic dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(en), .nicWrEn(we), .net_so(so), .net_ro(ro),
      .net_do(dout_net), .net_si(si), .net_ri(ri), .net_di(di),
      .net_polarity(pol)
   );

   cardinal_nic #(.DATA_WIDTH(64), .CNT_WIDTH(8)) dut_s (
      .clk(clk), .reset(reset), .addr(s_addr), .d_in(s_din),
      .d_out(s_dout), .nicEn(s_en), .nicWrEn(s_we), .net_so(s_so),
      .net_ro(1'b1), .net_do(s_do), .net_si(1'b0), .net_ri(s_ri),
      .net_di(64'h0), .net_polarity(1'b1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (pol_tog) pol = ~pol;
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] st(input int c, input bit f);
      logic [15:0] c16;
      c16 = c[15:0];
      return {32'h0, c16, 15'h0, f};
   endfunction

   // Behavioural model of the channel rules.
   logic [63:0] m_obuf = '0, m_ibuf = '0, m_dout = '0;
   bit          m_of = 0, m_if = 0;
   int          m_tx = 0, m_rx = 0;

   always @(posedge clk) begin : mdl
      bit snd, arr;
      if (reset) begin
         m_obuf = '0; m_ibuf = '0; m_dout = '0;
         m_of = 0; m_if = 0; m_tx = 0; m_rx = 0;
      end else begin
         snd = m_of && (m_obuf[63] == pol) && ro;
         arr = si && !m_if;
         if (en && !we) begin
            case (addr)
               2'd0: m_dout = m_ibuf;
               2'd1: m_dout = st(m_rx, m_if);
               2'd2: m_dout = m_obuf;
               default: m_dout = st(m_tx, m_of);
            endcase
            if (addr == 2'd0) m_if = 0;
         end
         if (en && we && addr == 2'd2 && !m_of) begin
            m_obuf = d_in;
            m_of = 1;
         end
         if (snd) begin
            m_of = 0;
            m_tx = (m_tx + 1) % 65536;
         end
         if (arr) begin
            m_ibuf = di;
            m_if = 1;
            m_rx = (m_rx + 1) % 65536;
         end
      end
   end

   always @(negedge clk) begin
      if (run_chk) begin
         chk("cyc_net_so", {63'h0, so},
             {63'h0, m_of && (m_obuf[63] == pol)});
         chk("cyc_net_ri", {63'h0, ri}, {63'h0, !m_if});
         chk("cyc_net_do", dout_net, m_obuf);
         chk("cyc_d_out", d_out, m_dout);
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic rd(input logic [1:0] a);
      addr = a; en = 1'b1; we = 1'b0;
      tick();
      en = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [63:0] v);
      addr = a; d_in = v; en = 1'b1; we = 1'b1;
      tick();
      en = 1'b0; we = 1'b0;
   endtask

   task automatic s_rd(input logic [1:0] a);
      s_addr = a; s_en = 1'b1; s_we = 1'b0;
      tick();
      s_en = 1'b0;
   endtask

   initial begin
      tick(2);
      reset = 1'b0;
      run_chk = 1'b1;
      chk("rst_ri", {63'h0, ri}, 64'h1);
      chk("rst_so", {63'h0, so}, 64'h0);
      chk("rst_do", dout_net, 64'h0);
      rd(2'b01);
      chk("rst_in_status", d_out, 64'h0);
      rd(2'b11);
      chk("rst_out_status", d_out, 64'h0);

      ro = 1'b1;
      wr(2'b10, 64'h8000_0000_0000_00AA);
      tick(3);
      rd(2'b11);
      chk("tx1_status", d_out, 64'h0001_0000);
      rd(2'b10);
      chk("outbuf_read", d_out, 64'h8000_0000_0000_00AA);

      ro = 1'b0;
      wr(2'b10, 64'h8000_0000_0000_00BB);
      wr(2'b10, 64'h0000_0000_0000_1234);
      chk("drop_do", dout_net, 64'h8000_0000_0000_00BB);
      tick(3);
      chk("hold_do", dout_net, 64'h8000_0000_0000_00BB);
      rd(2'b11);
      chk("hold_status", d_out, 64'h0001_0001);
      ro = 1'b1;
      tick(3);
      rd(2'b11);
      chk("tx2_status", d_out, 64'h0002_0000);

      si = 1'b1; di = 64'h55;
      tick();
      di = 64'h66;
      tick();
      chk("blk_ri", {63'h0, ri}, 64'h0);
      rd(2'b00);
      chk("rx_55", d_out, 64'h55);
      chk("ri_free", {63'h0, ri}, 64'h1);
      tick();
      si = 1'b0;
      rd(2'b01);
      chk("rx2_status", d_out, 64'h0002_0001);
      rd(2'b00);
      chk("rx_66", d_out, 64'h66);

      si = 1'b1; di = 64'h77;
      rd(2'b00);
      si = 1'b0;
      chk("stale_read", d_out, 64'h66);
      rd(2'b01);
      chk("set_wins", d_out, 64'h0003_0001);
      wr(2'b00, 64'hDEAD);
      wr(2'b01, 64'hBEEF);
      rd(2'b00);
      chk("wr00_ignored", d_out, 64'h77);

      pol_tog = 1'b0; pol = 1'b1; ro = 1'b0;
      wr(2'b10, 64'h8000_0000_0000_00CC);
      si = 1'b1; di = 64'h99;
      tick();
      si = 1'b0;
      chk("pre_rst_so", {63'h0, so}, 64'h1);
      chk("pre_rst_ri", {63'h0, ri}, 64'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("post_rst_so", {63'h0, so}, 64'h0);
      chk("post_rst_ri", {63'h0, ri}, 64'h1);
      chk("post_rst_do", dout_net, 64'h0);
      rd(2'b01);
      chk("post_rst_in", d_out, 64'h0);
      rd(2'b11);
      chk("post_rst_out", d_out, 64'h0);

      for (int i = 0; i < 255; i++) begin
         s_addr = 2'b10; s_din = 64'h8000_0000_0000_0001;
         s_en = 1'b1; s_we = 1'b1;
         tick();
         s_en = 1'b0; s_we = 1'b0;
         tick();
      end
      s_rd(2'b11);
      chk("wrap_pre", s_dout, 64'h00FF_0000);
      s_addr = 2'b10; s_en = 1'b1; s_we = 1'b1;
      tick();
      s_en = 1'b0; s_we = 1'b0;
      chk("wrap_so", {63'h0, s_so}, 64'h1);
      tick();
      s_rd(2'b11);
      chk("wrap_zero", s_dout, 64'h0);

      run_chk = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
